btn_debounce: RTL and testbench

//  Conditions the raw board push-buttons before they reach M_main's in_btn_0..3.
//  Per button it provides:
//   - a 2-FF synchroniser and a counter-based debouncer;
//   - one-cycle press and release strobes;
//   - a long-press strobe with optional auto-repeat.

---
 rtl/btn_debounce_if.sv | 45 ++++
 rtl/btn_debounce.sv | 203 ++++++++++++++++++++
 tb/tb_btn_debounce.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/btn_debounce_if.sv
// -----------------------------------------------------------------------------
// btn_debounce_if
// Carries the raw push-button pins into the debouncer and the conditioned
// levels and strobes back out to the consuming logic.
//
// Signals (all NUM_BTN wide, one bit per button):
//   in_btn_raw   raw, asynchronous button pins
//   out_btn      debounced level, 1 = pressed
//   out_press    one-cycle strobe when out_btn rises
//   out_release  one-cycle strobe when out_btn falls
//   out_hold     one-cycle strobe on a long press, then on every repeat period
//
// Modports:
//   master  the side that owns the pins and consumes the conditioned outputs
//   slave   the debouncer itself
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface btn_debounce_if #(
   parameter int NUM_BTN = 4
) ();

   logic [NUM_BTN-1:0] in_btn_raw;
   logic [NUM_BTN-1:0] out_btn;
   logic [NUM_BTN-1:0] out_press;
   logic [NUM_BTN-1:0] out_release;
   logic [NUM_BTN-1:0] out_hold;

   modport master (
      output in_btn_raw,
      input  out_btn,
      input  out_press,
      input  out_release,
      input  out_hold
   );

   modport slave (
      input  in_btn_raw,
      output out_btn,
      output out_press,
      output out_release,
      output out_hold
   );

endinterface

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Conditions the raw board push-buttons before they reach the main design.
// Each button gets its own 2-FF synchroniser, a counter-based debouncer,
// registered press/release strobes and a long-press detector with optional
// auto-repeat. Buttons are completely independent of one another.
//
// Parameters:
//   NUM_BTN          number of independent buttons
//   ACTIVE_LOW       1: a low raw pin means pressed (inverted after the synchroniser)
//   DEBOUNCE_CYCLES  consecutive disagreeing cycles needed to accept a new level (>=1)
//   HOLD_CYCLES      cycles pressed, from the accepted press, until out_hold fires (>=1)
//   REPEAT_CYCLES    auto-repeat period after the first out_hold; 0 disables repeat
//   CNT_W            counter width, must hold max(DEBOUNCE,HOLD,REPEAT)-1
//
// Ports:
//   clock        design clock
//   reset        synchronous, active-high; clears every register
//   btn          btn_debounce_if slave modport (raw pins in, levels/strobes out)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module btn_debounce #(
   parameter int NUM_BTN         = 4,
   parameter bit ACTIVE_LOW      = 1'b0,
   parameter int DEBOUNCE_CYCLES = 65536,
   parameter int HOLD_CYCLES     = 8388608,
   parameter int REPEAT_CYCLES   = 2097152,
   parameter int CNT_W           = 24
) (
   input  logic          clock,
   input  logic          reset,
   btn_debounce_if.slave btn
);

   // Terminal counts are precomputed at the counter width so every compare
   // below is a plain equality against a constant of matching width.
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST  =
      CNT_W'((REPEAT_CYCLES == 0) ? 0 : (REPEAT_CYCLES - 1));
   localparam bit               REPEAT_EN = (REPEAT_CYCLES != 0);

   localparam logic [NUM_BTN-1:0] POLARITY_MASK =
      ACTIVE_LOW ? {NUM_BTN{1'b1}} : {NUM_BTN{1'b0}};

   typedef enum logic [1:0] {
      HOLD_IDLE,
      HOLD_PRESSED,
      HOLD_REPEAT,
      HOLD_DONE
   } hold_state_t;

   logic [NUM_BTN-1:0] sync1_q;
   logic [NUM_BTN-1:0] sync2_q;
   logic [NUM_BTN-1:0] s;

   // Two-stage synchroniser for the asynchronous pins. Everything downstream
   // sees only the second stage, so a metastable first stage never reaches
   // the counters or the FSM.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn.in_btn_raw;
         sync2_q <= sync1_q;
      end
   end

   // Normalise polarity once, so that s = 1 always means "pressed".
   assign s = sync2_q ^ POLARITY_MASK;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn

      logic [CNT_W-1:0] dcnt_q;
      logic             lvl_q;
      logic             lvl_prev_q;
      logic             press_q;
      logic             release_q;
      logic             hold_q;
      logic             rise;
      logic             fall;

      hold_state_t      state_q;
      hold_state_t      state_d;
      logic [CNT_W-1:0] hcnt_q;
      logic [CNT_W-1:0] hcnt_d;
      logic             hold_d;

      // Debouncer: count consecutive cycles in which the synchronised input
      // disagrees with the accepted level. A single cycle of agreement
      // restarts the count, so only a disagreement lasting DEBOUNCE_CYCLES
      // edges flips the level. The count is cleared on the flip, so it can
      // never exceed DEB_LAST.
      always_ff @(posedge clock) begin
         if (reset) begin
            dcnt_q <= '0;
            lvl_q  <= 1'b0;
         end else if (s[i] == lvl_q) begin
            dcnt_q <= '0;
         end else if (dcnt_q == DEB_LAST) begin
            dcnt_q <= '0;
            lvl_q  <= s[i];
         end else begin
            dcnt_q <= dcnt_q + 1'b1;
         end
      end

      // Edge detection on the accepted level. The delayed copy lets the
      // strobes be fully registered: they are high for the single cycle
      // that follows the cycle in which the level changed.
      assign rise = lvl_q & ~lvl_prev_q;
      assign fall = ~lvl_q & lvl_prev_q;

      always_ff @(posedge clock) begin
         if (reset) begin
            lvl_prev_q <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
         end else begin
            lvl_prev_q <= lvl_q;
            press_q    <= rise;
            release_q  <= fall;
         end
      end

      // Long-press FSM state and counter registers. The hold strobe is
      // registered too, so it appears the cycle after the threshold compare.
      always_ff @(posedge clock) begin
         if (reset) begin
            state_q <= HOLD_IDLE;
            hcnt_q  <= '0;
            hold_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            hold_q  <= hold_d;
         end
      end

      // Long-press FSM next state. The press is timed from the same edge
      // that raises the press strobe. A falling level wins over everything
      // else, so a hold can never be issued on the edge that issues the
      // release. The counter is cleared at every threshold, so it never
      // wraps. With repeat disabled the FSM parks in DONE until release.
      always_comb begin
         state_d = state_q;
         hcnt_d  = hcnt_q;
         hold_d  = 1'b0;

         if (fall) begin
            state_d = HOLD_IDLE;
            hcnt_d  = '0;
         end else begin
            unique case (state_q)
               HOLD_IDLE: begin
                  if (rise) begin
                     state_d = HOLD_PRESSED;
                     hcnt_d  = '0;
                  end
               end

               HOLD_PRESSED: begin
                  if (hcnt_q == HOLD_LAST) begin
                     hold_d  = 1'b1;
                     hcnt_d  = '0;
                     state_d = REPEAT_EN ? HOLD_REPEAT : HOLD_DONE;
                  end else begin
                     hcnt_d = hcnt_q + 1'b1;
                  end
               end

               HOLD_REPEAT: begin
                  if (hcnt_q == REP_LAST) begin
                     hold_d = 1'b1;
                     hcnt_d = '0;
                  end else begin
                     hcnt_d = hcnt_q + 1'b1;
                  end
               end

               HOLD_DONE: begin
                  hcnt_d = '0;
               end

               default: begin
                  state_d = HOLD_IDLE;
                  hcnt_d  = '0;
               end
            endcase
         end
      end

      // Each button drives only its own bit of the shared output vectors.
      assign btn.out_btn[i]     = lvl_q;
      assign btn.out_press[i]   = press_q;
      assign btn.out_release[i] = release_q;
      assign btn.out_hold[i]    = hold_q;

   end

endmodule

// File: tb/tb_btn_debounce.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce
// Scoreboard bench for btn_debounce. Expected level changes and strobes are
// pushed with their due cycle when stimulus is driven, and taken off the
// queue on the cycle they are due. Every cycle the whole output set is
// compared, so both missing and spurious strobes are caught.
// Two instances: dut (repeat enabled) and dut_nr (repeat disabled).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_btn_debounce;

   localparam int K_PRESS = 0;
   localparam int K_REL   = 1;
   localparam int K_HOLD  = 2;
   localparam int K_SET   = 3;
   localparam int K_CLR   = 4;
   localparam int K_HOLD2 = 5;

   typedef struct {
      int         cyc;
      int         kind;
      logic [3:0] mask;
   } ev_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   tests = 0;
   int   fails = 0;

   ev_t        sb[$];
   logic [3:0] exp_btn   = '0;
   logic [3:0] exp_press = '0;
   logic [3:0] exp_rel   = '0;
   logic [3:0] exp_hold  = '0;
   logic [3:0] exp_hold2 = '0;

   btn_debounce_if #(.NUM_BTN(4)) bus ();
   btn_debounce_if #(.NUM_BTN(4)) bus2 ();

   btn_debounce #(
      .NUM_BTN(4), .ACTIVE_LOW(1'b0), .DEBOUNCE_CYCLES(4),
      .HOLD_CYCLES(16), .REPEAT_CYCLES(8), .CNT_W(8)
   ) dut (
      .clock(clock),
      .reset(reset),
      .btn(bus)
   );

   btn_debounce #(
      .NUM_BTN(4), .ACTIVE_LOW(1'b0), .DEBOUNCE_CYCLES(4),
      .HOLD_CYCLES(16), .REPEAT_CYCLES(0), .CNT_W(8)
   ) dut_nr (
      .clock(clock),
      .reset(reset),
      .btn(bus2)
   );

   always #5 clock = ~clock;

   // Edge counter: after posedge n settles, cyc == n.
   always @(posedge clock) cyc <= cyc + 1;

   task automatic sb_push(input int c, input int k, input logic [3:0] m);
      ev_t e;
      e.cyc  = c;
      e.kind = k;
      e.mask = m;
      sb.push_back(e);
   endtask

   task automatic sb_take(input int c, input int k, output logic [3:0] m);
      m = '0;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == c && sb[i].kind == k) begin
            m |= sb[i].mask;
            sb.delete(i);
         end
      end
   endtask

   task automatic sb_purge_future();
      for (int i = sb.size() - 1; i >= 0; i--)
         if (sb[i].cyc > cyc) sb.delete(i);
   endtask

   // Raw edge driven now (after edge n) is first sampled at n+1: level
   // changes at n+6, press strobe at n+7, holds at n+23 then every 8.
   task automatic sched_press(input logic [3:0] mask);
      bus.in_btn_raw = bus.in_btn_raw | mask;
      for (int b = 0; b < 4; b++) begin
         if (mask[b]) begin
            sb_push(cyc + 6, K_SET, 4'(1 << b));
            sb_push(cyc + 7, K_PRESS, 4'(1 << b));
            for (int j = 0; j < 30; j++)
               sb_push(cyc + 23 + 8 * j, K_HOLD, 4'(1 << b));
         end
      end
   endtask

   // Level falls at m+6 and release strobes at m+7; holds after m+6 vanish.
   task automatic sched_release(input logic [3:0] mask);
      bus.in_btn_raw = bus.in_btn_raw & ~mask;
      for (int i = sb.size() - 1; i >= 0; i--)
         if (sb[i].kind == K_HOLD && (sb[i].mask & mask) != 4'h0 && sb[i].cyc > cyc + 6)
            sb.delete(i);
      for (int b = 0; b < 4; b++) begin
         if (mask[b]) begin
            sb_push(cyc + 6, K_CLR, 4'(1 << b));
            sb_push(cyc + 7, K_REL, 4'(1 << b));
         end
      end
   endtask

   // Advance one edge, sample 1 ns later, and pull this cycle's expectations.
   task automatic step();
      logic [3:0] set_m;
      logic [3:0] clr_m;
      @(posedge clock);
      #1;
      sb_take(cyc, K_PRESS, exp_press);
      sb_take(cyc, K_REL, exp_rel);
      sb_take(cyc, K_HOLD, exp_hold);
      sb_take(cyc, K_HOLD2, exp_hold2);
      sb_take(cyc, K_SET, set_m);
      sb_take(cyc, K_CLR, clr_m);
      exp_btn = (exp_btn | set_m) & ~clr_m;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.in_btn_raw  = 4'hF;
      bus2.in_btn_raw = 4'h0;
      repeat (3) begin
         step();
         tests++;
         if ({bus.out_btn, bus.out_press, bus.out_release, bus.out_hold} !== 16'h0000) begin
            fails++;
            $display("[TB] FAIL reset_clear cyc %0d: got %h, required 0000", cyc,
                     {bus.out_btn, bus.out_press, bus.out_release, bus.out_hold});
         end
      end
      reset = 1'b0;
      sched_press(4'hF);
      repeat (8) begin
         step();
         tests++;
         if ({bus.out_btn, bus.out_press, bus.out_release, bus.out_hold} !==
             {exp_btn, exp_press, exp_rel, exp_hold}) begin
            fails++;
            $display("[TB] FAIL reset_exit cyc %0d: got %h, required %h", cyc,
                     {bus.out_btn, bus.out_press, bus.out_release, bus.out_hold},
                     {exp_btn, exp_press, exp_rel, exp_hold});
         end
      end
      sched_release(4'hF);
      repeat (9) begin
         step();
         tests++;
         if ({bus.out_btn, bus.out_press, bus.out_release, bus.out_hold} !==
             {exp_btn, exp_press, exp_rel, exp_hold}) begin
            fails++;
            $display("[TB] FAIL reset_release cyc %0d: got %h, required %h", cyc,
                     {bus.out_btn, bus.out_press, bus.out_release, bus.out_hold},
                     {exp_btn, exp_press, exp_rel, exp_hold});
         end
      end
   endtask

   task automatic test_press_latency();
      sched_press(4'h1);
      repeat (10) begin
         step();
         tests++;
         if ({bus.out_btn, bus.out_press, bus.out_release, bus.out_hold} !==
             {exp_btn, exp_press, exp_rel, exp_hold}) begin
            fails++;
            $display("[TB] FAIL press_latency cyc %0d: got %h, required %h", cyc,
                     {bus.out_btn, bus.out_press, bus.out_release, bus.out_hold},
                     {exp_btn, exp_press, exp_rel, exp_hold});
         end
      end
      sched_release(4'h1);
      repeat (8) begin
         step();
         tests++;
         if ({bus.out_btn, bus.out_press, bus.out_release, bus.out_hold} !==
             {exp_btn, exp_press, exp_rel, exp_hold}) begin
            fails++;
            $display("[TB] FAIL press_release cyc %0d: got %h, required %h", cyc,
                     {bus.out_btn, bus.out_press, bus.out_release, bus.out_hold},
                     {exp_btn, exp_press, exp_rel, exp_hold});
         end
      end
   endtask

   task automatic test_glitch();
      int pattern[4] = '{3, 1, 3, 10};
      for (int p = 0; p < 4; p++) begin
         bus.in_btn_raw[1] = (p % 2 == 0);
         repeat (pattern[p]) begin
            step();
            tests++;
            if ({bus.out_btn, bus.out_press, bus.out_release, bus.out_hold} !==
                {exp_btn, exp_press, exp_rel, exp_hold}) begin
               fails++;
               $display("[TB] FAIL glitch cyc %0d: got %h, required %h", cyc,
                        {bus.out_btn, bus.out_press, bus.out_release, bus.out_hold},
                        {exp_btn, exp_press, exp_rel, exp_hold});
            end
         end
      end
   endtask

   task automatic test_hold_repeat();
      sched_press(4'h4);
      repeat (60) begin
         step();
         tests++;
         if ({bus.out_btn, bus.out_press, bus.out_release, bus.out_hold} !==
             {exp_btn, exp_press, exp_rel, exp_hold}) begin
            fails++;
            $display("[TB] FAIL hold_repeat cyc %0d: got %h, required %h", cyc,
                     {bus.out_btn, bus.out_press, bus.out_release, bus.out_hold},
                     {exp_btn, exp_press, exp_rel, exp_hold});
         end
      end
      sched_release(4'h4);
      repeat (10) begin
         step();
         tests++;
         if ({bus.out_btn, bus.out_press, bus.out_release, bus.out_hold} !==
             {exp_btn, exp_press, exp_rel, exp_hold}) begin
            fails++;
            $display("[TB] FAIL hold_release cyc %0d: got %h, required %h", cyc,
                     {bus.out_btn, bus.out_press, bus.out_release, bus.out_hold},
                     {exp_btn, exp_press, exp_rel, exp_hold});
         end
      end
   endtask

   task automatic test_no_repeat();
      bus2.in_btn_raw[3] = 1'b1;
      sb_push(cyc + 23, K_HOLD2, 4'h8);
      for (int c = 0; c < 70; c++) begin
         if (c == 60) bus2.in_btn_raw[3] = 1'b0;
         step();
         tests++;
         if (bus2.out_hold !== exp_hold2) begin
            fails++;
            $display("[TB] FAIL no_repeat_hold cyc %0d: got %h, required %h", cyc,
                     bus2.out_hold, exp_hold2);
         end
      end
   endtask

   task automatic test_back_to_back();
      sched_press(4'h9);
      repeat (25) begin
         step();
         tests++;
         if ({bus.out_btn, bus.out_press, bus.out_release, bus.out_hold} !==
             {exp_btn, exp_press, exp_rel, exp_hold}) begin
            fails++;
            $display("[TB] FAIL simultaneous cyc %0d: got %h, required %h", cyc,
                     {bus.out_btn, bus.out_press, bus.out_release, bus.out_hold},
                     {exp_btn, exp_press, exp_rel, exp_hold});
         end
      end
      reset = 1'b1;
      bus.in_btn_raw = 4'h0;
      sb_purge_future();
      exp_btn = 4'h0;
      for (int c = 0; c < 13; c++) begin
         if (c == 3) reset = 1'b0;
         step();
         tests++;
         if ({bus.out_btn, bus.out_press, bus.out_release, bus.out_hold} !==
             {exp_btn, exp_press, exp_rel, exp_hold}) begin
            fails++;
            $display("[TB] FAIL reset_mid_hold cyc %0d: got %h, required %h", cyc,
                     {bus.out_btn, bus.out_press, bus.out_release, bus.out_hold},
                     {exp_btn, exp_press, exp_rel, exp_hold});
         end
      end
   endtask

   initial begin
      bus.in_btn_raw  = 4'hF;
      bus2.in_btn_raw = 4'h0;
      test_reset();
      test_press_latency();
      test_glitch();
      test_hold_repeat();
      test_no_repeat();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
